// File: rtl/pic_pkg.sv
// Shared encodings for the PIC16F84-compatible reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pic_pkg;

    typedef enum logic [2:0] {
        S_HOLD  = 3'd0,
        S_OST   = 3'd1,
        S_PWRT  = 3'd2,
        S_RUN   = 3'd3,
        S_SWRST = 3'd4
    } pic_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_POR  = 2'b01,
        CAUSE_WDT  = 2'b10,
        CAUSE_EXT  = 2'b11
    } rst_cause_e;

    localparam int MIN_SYNC_STAGES = 2;

    // The core is released only in RUN; every other state, legal or not, holds it.
    function automatic logic holds_core(input pic_state_e s);
        return (s != S_RUN);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert flop chain for a raw reset or other async level.
// Latency: assert immediate, deassert after STAGES rising clk edges.
// Backpressure: none.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= chain << 1;
        end
    end

    assign rst_sync = chain[STAGES-1];

endmodule

// File: rtl/pic_reset_ctl.sv
// Reset sequencer for the PIC core: async assert, sync release after OST then PWRT waits.
// Latency: core_reset falls after edge SYNC_STAGES+OST_CYCLES+PWRT_CYCLES; WDT/EXT hold HOLD_CYCLES edges.
// Backpressure: none; wdt_timeout/ext_rst_req are single-cycle pulses, ignored outside RUN.
module pic_reset_ctl
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OST_CYCLES  = 8,
    parameter int PWRT_CYCLES = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wdt_timeout,
    input  logic       ext_rst_req,
    input  logic       cause_clr,
    output logic       core_reset,
    output logic       core_ready,
    output logic [1:0] rst_cause,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] OST_LAST  = CNT_W'(OST_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWRT_LAST = CNT_W'(PWRT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             rst_sync;
    pic_state_e       state_q;
    pic_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    rst_cause_e       cause_q;
    rst_cause_e       cause_d;
    logic             core_reset_d;

    // The state flop leaving S_HOLD is the last synchronizer stage, so the
    // release lands on edge SYNC_STAGES and OST counting starts right there.
    reset_sync #(
        .STAGES (SYNC_STAGES - 1)
    ) u_reset_sync (
        .clk      (clk),
        .rst      (reset),
        .rst_sync (rst_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            cause_q    <= CAUSE_POR;
            core_reset <= 1'b1;
            core_ready <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            core_reset <= core_reset_d;
            core_ready <= ~core_reset_d;
        end
    end

    // Counter is cleared on every transition, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        cause_d = cause_q;
        case (state_q)
            S_HOLD: begin
                if (!rst_sync) begin
                    state_d = S_OST;
                end
            end
            S_OST: begin
                if (cnt_q == OST_LAST) begin
                    state_d = S_PWRT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PWRT: begin
                if (cnt_q == PWRT_LAST) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (wdt_timeout) begin
                    state_d = S_SWRST;
                    cause_d = CAUSE_WDT;
                end else if (ext_rst_req) begin
                    state_d = S_SWRST;
                    cause_d = CAUSE_EXT;
                end else if (cause_clr) begin
                    cause_d = CAUSE_NONE;
                end
            end
            S_SWRST: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    always_comb begin
        core_reset_d = holds_core(state_d);
    end

    assign rst_cause = cause_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pic_reset_ctl.sv
// Directed bench for pic_reset_ctl: power-up timing, WDT/EXT holds, cause priority, reset glitches.
`timescale 1ns/1ps
module tb_pic_reset_ctl;

    localparam int SYNC = 2;
    localparam int OST  = 8;
    localparam int PWRT = 16;
    localparam int REL  = SYNC + OST + PWRT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wdt_timeout = 1'b0;
    logic       ext_rst_req = 1'b0;
    logic       cause_clr = 1'b0;
    logic       core_reset;
    logic       core_ready;
    logic [1:0] rst_cause;
    logic [2:0] state_dbg;

    int n_chk  = 0;
    int n_pass = 0;

    pic_reset_ctl dut (
        .clk         (clk),
        .reset       (reset),
        .wdt_timeout (wdt_timeout),
        .ext_rst_req (ext_rst_req),
        .cause_clr   (cause_clr),
        .core_reset  (core_reset),
        .core_ready  (core_ready),
        .rst_cause   (rst_cause),
        .state_dbg   (state_dbg)
    );

    always #8.333 clk = ~clk;

    typedef struct {
        logic       wdt;
        logic       ext;
        logic       clr;
        logic       exp_rst;
        logic       exp_rdy;
        logic [1:0] exp_cause;
        logic [2:0] exp_state;
    } vec_t;

    vec_t tbl [28];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_out(input string tag, input int r, input int rdy, input int cause, input int st);
        chk({tag, " core_reset"}, int'(core_reset), r);
        chk({tag, " core_ready"}, int'(core_ready), rdy);
        chk({tag, " rst_cause"},  int'(rst_cause),  cause);
        chk({tag, " state_dbg"},  int'(state_dbg),  st);
    endtask

    function automatic int exp_st(input int k);
        if (k < SYNC)       return 0;
        if (k < SYNC + OST) return 1;
        if (k < REL)        return 2;
        return 3;
    endfunction

    // Walks edges 1..last_edge after a reset release; optional wdt pulse sampled at wdt_edge.
    task automatic release_seq(input string tag, input int wdt_edge, input int last_edge);
        for (int k = 1; k <= last_edge; k++) begin
            wdt_timeout = (k == wdt_edge);
            @(posedge clk);
            #1;
            wdt_timeout = 1'b0;
            chk_out($sformatf("%s e%0d", tag, k), (k < REL) ? 1 : 0, (k < REL) ? 0 : 1, 1, exp_st(k));
        end
    endtask

    // 3 ns reset pulse landing between clock edges.
    task automatic glitch(input string tag);
        #2 reset = 1'b1;
        #1 chk_out(tag, 1, 0, 1, 0);
        #2 reset = 1'b0;
    endtask

    task automatic setv(input int i, input logic w, input logic e, input logic c,
                        input logic r, input logic rdy, input logic [1:0] ca, input logic [2:0] st);
        tbl[i].wdt = w;  tbl[i].ext = e;  tbl[i].clr = c;
        tbl[i].exp_rst = r;  tbl[i].exp_rdy = rdy;
        tbl[i].exp_cause = ca;  tbl[i].exp_state = st;
    endtask

    initial begin
        //        wdt   ext   clr   rst   rdy   cause  state
        setv( 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'd3);
        setv( 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'd3);
        setv( 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv( 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv( 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv( 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv( 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 3'd3);
        setv( 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv( 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv( 9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv(10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv(11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'd3);
        setv(12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 3'd4);
        setv(13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 3'd4);
        setv(14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 3'd4);
        setv(15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 3'd4);
        setv(16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'd3);
        setv(17, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'd3);
        setv(18, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 3'd4);
        setv(19, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 3'd4);
        setv(20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 3'd4);
        setv(21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 3'd4);
        setv(22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'd3);
        setv(23, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'd4);
        setv(24, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv(25, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv(26, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'd4);
        setv(27, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'd3);

        // Power-up: reset held 40 ns, first edge with reset low is edge 1.
        reset = 1'b1;
        #35 chk_out("por_hold", 1, 0, 1, 0);
        #5  reset = 1'b0;
        release_seq("pwrup", 0, REL);

        // RUN-state vectors: inputs live for exactly one sampling edge.
        for (int i = 0; i < 28; i++) begin
            wdt_timeout = tbl[i].wdt;
            ext_rst_req = tbl[i].ext;
            cause_clr   = tbl[i].clr;
            @(posedge clk);
            #1;
            wdt_timeout = 1'b0;
            ext_rst_req = 1'b0;
            cause_clr   = 1'b0;
            chk_out($sformatf("vec%0d", i), int'(tbl[i].exp_rst), int'(tbl[i].exp_rdy),
                    int'(tbl[i].exp_cause), int'(tbl[i].exp_state));
        end

        // Glitch from RUN with cause=WDT, then a second glitch mid-PWRT.
        glitch("glitch_run");
        release_seq("rst2", 0, 15);
        glitch("glitch_pwrt");

        // WDT pulse during OST must not disturb the release timing or cause.
        release_seq("rst3", 5, REL);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
